// File: rtl/fetch_req_ctrl_pkg.sv
// Shared widths, reset PC and redirect-priority helpers for the instruction fetch front end.
package fetch_req_ctrl_pkg;

  localparam int F2D_WID     = 65;
  localparam int D2F_BRC_WID = 33;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  localparam logic [1:0] REDIR_NONE = 2'd0;
  localparam logic [1:0] REDIR_EX   = 2'd1;
  localparam logic [1:0] REDIR_ERTN = 2'd2;
  localparam logic [1:0] REDIR_BR   = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } redir_t;

  // Exception beats ertn, ertn beats a taken branch.
  function automatic logic [1:0] redir_src(input logic ex, input logic ertn, input logic br);
    if (ex) return REDIR_EX;
    if (ertn) return REDIR_ERTN;
    if (br) return REDIR_BR;
    return REDIR_NONE;
  endfunction

  function automatic redir_t redir_pick(input logic ex, input logic ertn, input logic br,
                                        input logic [31:0] ex_pc, input logic [31:0] ertn_pc,
                                        input logic [31:0] br_pc);
    redir_t r;
    r.valid = ex | ertn | br;
    case (redir_src(ex, ertn, br))
      REDIR_EX:   r.pc = ex_pc;
      REDIR_ERTN: r.pc = ertn_pc;
      REDIR_BR:   r.pc = br_pc;
      default:    r.pc = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_req_ctrl_cancel_cnt.sv
// Outstanding-request and cancelled-response counters for the in-order instruction bus.
module fetch_cancel_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] ostd_cnt_o,
  output logic [CNT_W-1:0] cancel_cnt_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] ostd_q, ostd_d;
  logic [CNT_W-1:0] cancel_q, cancel_d;

  always_comb begin
    ostd_d = ostd_q;
    if (inc_i && !dec_i) ostd_d = ostd_q + ONE;
    else if (!inc_i && dec_i) ostd_d = ostd_q - ONE;

    // On a flush every response still in flight belongs to a stale fetch.
    cancel_d = cancel_q;
    if (flush_i) cancel_d = ostd_d;
    else if (dec_i && cancel_q != '0) cancel_d = cancel_q - ONE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ostd_q   <= '0;
      cancel_q <= '0;
    end else begin
      ostd_q   <= ostd_d;
      cancel_q <= cancel_d;
    end
  end

  assign ostd_cnt_o   = ostd_q;
  assign cancel_cnt_o = cancel_q;

endmodule

// File: rtl/fetch_req_ctrl.sv
// Pre-IF/IF front end: PC generation, SRAM-like request handshake, stale-response
// cancellation and a one-entry instruction buffer feeding the ID stage.
module fetch_req_ctrl
  import fetch_req_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CNT_W    = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   inst_sram_req,
  output logic                   inst_sram_wr,
  output logic [1:0]             inst_sram_size,
  output logic [3:0]             inst_sram_wstrb,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  input  logic                   ds_allowin,
  input  logic [D2F_BRC_WID-1:0] br_collect,
  output logic                   fs_to_ds_valid,
  output logic [F2D_WID-1:0]     fs_to_ds_bus,
  input  logic                   wb_ex,
  input  logic                   ertn_flush,
  input  logic [31:0]            ex_entry,
  input  logic [31:0]            ertn_entry
);

  logic        br_taken;
  logic [31:0] br_target;
  redir_t      redir_now;
  logic        redirect_now;
  logic        flush_all;

  assign {br_taken, br_target} = br_collect;
  assign redir_now    = redir_pick(wb_ex, ertn_flush, br_taken, ex_entry, ertn_entry, br_target);
  assign redirect_now = redir_now.valid;
  assign flush_all    = wb_ex | ertn_flush;

  logic [31:0] pf_pc_q, pf_pc_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_valid_q, redir_valid_d;
  logic        adef_hold_q, adef_hold_d;
  logic        fs_valid_q, fs_valid_d;
  logic        fs_adef_q, fs_adef_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic [CNT_W-1:0] ostd_cnt, cancel_cnt;
  logic [31:0]      fetch_pc;
  logic             pf_adef, ostd_full, data_live;
  logic             fs_waiting, fs_ready_go, fs_leave, fs_allowin;
  logic             hs, adef_load;
  logic [31:0]      fs_inst;

  // A latched redirect target takes over the fetch address until it is accepted.
  assign fetch_pc  = redir_valid_q ? redir_pc_q : pf_pc_q;
  assign pf_adef   = fetch_pc[1:0] != 2'b00;
  assign ostd_full = &ostd_cnt;
  assign data_live = inst_sram_data_ok & (cancel_cnt == '0);

  assign fs_waiting  = fs_valid_q & ~fs_adef_q & ~buf_valid_q;
  assign fs_ready_go = buf_valid_q | data_live | fs_adef_q;
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~redirect_now;
  assign fs_leave   = fs_to_ds_valid & ds_allowin;
  assign fs_allowin = ~fs_valid_q | fs_leave;

  assign inst_sram_req = resetn & ~redirect_now & fs_allowin & ~ostd_full & ~pf_adef;
  assign hs            = inst_sram_req & inst_sram_addr_ok;
  // A misaligned PC fills the slot once, then fetch idles until the next redirect.
  assign adef_load     = resetn & ~redirect_now & fs_allowin & pf_adef & ~adef_hold_q;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc;

  assign fs_inst      = buf_valid_q ? buf_inst_q : (fs_adef_q ? 32'h0 : inst_sram_rdata);
  assign fs_to_ds_bus = {fs_adef_q, fs_inst, fs_pc_q};

  fetch_cancel_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk          (clk),
    .resetn       (resetn),
    .inc_i        (hs),
    .dec_i        (inst_sram_data_ok),
    .flush_i      (redirect_now),
    .ostd_cnt_o   (ostd_cnt),
    .cancel_cnt_o (cancel_cnt)
  );

  always_comb begin
    pf_pc_d       = pf_pc_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = redir_valid_q;
    adef_hold_d   = adef_hold_q;
    if (redirect_now) begin
      redir_valid_d = 1'b1;
      redir_pc_d    = redir_now.pc;
      adef_hold_d   = 1'b0;
    end else if (hs) begin
      pf_pc_d       = fetch_pc + 32'd4;
      redir_valid_d = 1'b0;
    end else if (adef_load) begin
      pf_pc_d       = fetch_pc;
      redir_valid_d = 1'b0;
      adef_hold_d   = 1'b1;
    end
  end

  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_adef_d   = fs_adef_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;
    if (redirect_now) begin
      // A branch only kills a fetch still waiting on the bus; WB flushes kill everything.
      if (flush_all) begin
        fs_valid_d  = 1'b0;
        buf_valid_d = 1'b0;
      end else if (fs_waiting) begin
        fs_valid_d = 1'b0;
      end
    end else begin
      if (fs_leave) begin
        fs_valid_d  = 1'b0;
        buf_valid_d = 1'b0;
      end else if (fs_waiting && data_live && !ds_allowin) begin
        buf_valid_d = 1'b1;
        buf_inst_d  = inst_sram_rdata;
      end
      if (hs || adef_load) begin
        fs_valid_d = 1'b1;
        fs_adef_d  = adef_load;
        fs_pc_d    = fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pf_pc_q       <= RESET_PC;
      redir_pc_q    <= '0;
      redir_valid_q <= 1'b0;
      adef_hold_q   <= 1'b0;
      fs_valid_q    <= 1'b0;
      fs_adef_q     <= 1'b0;
      fs_pc_q       <= '0;
      buf_valid_q   <= 1'b0;
      buf_inst_q    <= '0;
    end else begin
      pf_pc_q       <= pf_pc_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
      adef_hold_q   <= adef_hold_d;
      fs_valid_q    <= fs_valid_d;
      fs_adef_q     <= fs_adef_d;
      fs_pc_q       <= fs_pc_d;
      buf_valid_q   <= buf_valid_d;
      buf_inst_q    <= buf_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Self-checking bench for fetch_req_ctrl: in-order bus responder, directed scenarios and a
// randomized run checked against a sequential-PC program-flow model.
module tb_fetch_req_ctrl;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic [32:0] br_collect;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        wb_ex, ertn_flush;
  logic [31:0] ex_entry, ertn_entry;

  fetch_req_ctrl dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .ds_allowin(ds_allowin), .br_collect(br_collect),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .wb_ex(wb_ex), .ertn_flush(ertn_flush), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } bus_ent_t;

  bus_ent_t    bus_q[$];
  logic [31:0] issued_q[$];
  logic [64:0] deliv_q[$];

  int unsigned cyc, ok_pct, dok_pct, ds_pct, lat;
  logic        ovr_en;
  logic [31:0] ovr_inst, nxt_ex_entry, nxt_ertn_entry;
  int          checks, failures;

  logic        obs_req, obs_ok, obs_valid, obs_redir, obs_deliv;
  logic [31:0] obs_addr;
  logic [64:0] obs_bus;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h1234, pc[31:16]} ^ 32'h0000_a5a5;
  endfunction

  function automatic logic [31:0] issued_at(input int i);
    if (i < issued_q.size()) return issued_q[i];
    return 'x;
  endfunction

  function automatic logic [64:0] deliv_at(input int i);
    if (i < deliv_q.size()) return deliv_q[i];
    return 'x;
  endfunction

  // driver: one bus/ID cycle, inputs applied after the edge, outputs sampled on the falling edge
  task automatic step_r(input logic ex, input logic ertn, input logic br, input logic [31:0] tgt);
    @(posedge clk); #1;
    wb_ex      = ex;
    ertn_flush = ertn;
    br_collect = {br, tgt};
    ex_entry   = nxt_ex_entry;
    ertn_entry = nxt_ertn_entry;
    inst_sram_addr_ok = ($urandom_range(0, 99) < ok_pct);
    if (bus_q.size() != 0 && bus_q[0].ready <= cyc && $urandom_range(0, 99) < dok_pct) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = ovr_en ? ovr_inst : inst_of(bus_q[0].addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
    ds_allowin = ($urandom_range(0, 99) < ds_pct);
    @(negedge clk);
    obs_req   = inst_sram_req;
    obs_ok    = inst_sram_addr_ok;
    obs_addr  = inst_sram_addr;
    obs_valid = fs_to_ds_valid;
    obs_bus   = fs_to_ds_bus;
    obs_redir = ex | ertn | br;
    obs_deliv = fs_to_ds_valid & ds_allowin;
    if (inst_sram_req && inst_sram_addr_ok) begin
      bus_q.push_back('{inst_sram_addr, cyc + 1 + lat});
      issued_q.push_back(inst_sram_addr);
    end
    if (inst_sram_data_ok) void'(bus_q.pop_front());
    if (obs_deliv) deliv_q.push_back(fs_to_ds_bus);
    cyc++;
  endtask

  task automatic step();
    step_r(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clear_inputs();
    wb_ex = 1'b0; ertn_flush = 1'b0; br_collect = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    ds_allowin = 1'b0; ovr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_q.delete(); issued_q.delete(); deliv_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs req=%b valid=%b required 0 0", inst_sram_req, fs_to_ds_valid);
    end
    checks++;
    if (inst_sram_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_pc got=%h required=%h", inst_sram_addr, RST_PC);
    end
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
      failures++;
      $display("FAIL const_outputs wr=%b size=%b wstrb=%h wdata=%h", inst_sram_wr, inst_sram_size,
               inst_sram_wstrb, inst_sram_wdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
      failures++;
      $display("FAIL reset_release req=%b addr=%h required 1 %h", inst_sram_req, inst_sram_addr, RST_PC);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] pc;
    do_reset();
    ok_pct = 100; dok_pct = 100; lat = 0; ds_pct = 100;
    repeat (6) step();
    for (int i = 0; i < 3; i++) begin
      pc = RST_PC + 32'(4 * i);
      checks++;
      if (issued_at(i) !== pc) begin
        failures++;
        $display("FAIL seq_addr[%0d] got=%h required=%h", i, issued_at(i), pc);
      end
      checks++;
      if (deliv_at(i) !== {1'b0, inst_of(pc), pc}) begin
        failures++;
        $display("FAIL seq_deliv[%0d] got=%h required=%h", i, deliv_at(i), {1'b0, inst_of(pc), pc});
      end
    end
  endtask

  task automatic test_addr_stall();
    do_reset();
    ok_pct = 0; dok_pct = 100; lat = 0; ds_pct = 100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin
        failures++;
        $display("FAIL stall_hold[%0d] req=%b addr=%h required 1 %h", i, obs_req, obs_addr, RST_PC);
      end
    end
    ok_pct = 100; step();
    ok_pct = 0; repeat (3) step();
    checks++;
    if (issued_q.size() != 1 || deliv_q.size() != 1) begin
      failures++;
      $display("FAIL stall_single issued=%0d delivered=%0d required 1 1", issued_q.size(), deliv_q.size());
    end
    checks++;
    if (deliv_at(0) !== {1'b0, inst_of(RST_PC), RST_PC}) begin
      failures++;
      $display("FAIL stall_deliv got=%h", deliv_at(0));
    end
  endtask

  task automatic test_branch_cancel();
    do_reset();
    ok_pct = 100; dok_pct = 100; lat = 0; ds_pct = 100;
    for (int n = 0; n < 20 && issued_q.size() < 2; n++) step();
    lat = 6;
    for (int n = 0; n < 20 && issued_q.size() < 3; n++) step();
    lat = 0;
    step_r(1'b0, 1'b0, 1'b1, 32'h1c00_0100);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      failures++;
      $display("FAIL br_cycle valid=%b req=%b required 0 0", obs_valid, obs_req);
    end
    repeat (14) step();
    checks++;
    if (issued_at(2) !== 32'h1c00_0008 || issued_at(3) !== 32'h1c00_0100) begin
      failures++;
      $display("FAIL br_next_addr got=%h,%h required 1c000008,1c000100", issued_at(2), issued_at(3));
    end
    checks++;
    if (deliv_at(2) !== {1'b0, inst_of(32'h1c00_0100), 32'h1c00_0100}) begin
      failures++;
      $display("FAIL br_target_deliv got=%h", deliv_at(2));
    end
    checks++;
    if (deliv_at(1) !== {1'b0, inst_of(RST_PC + 32'd4), RST_PC + 32'd4} ||
        deliv_at(3) !== {1'b0, inst_of(32'h1c00_0104), 32'h1c00_0104}) begin
      failures++;
      $display("FAIL br_neighbours got=%h %h", deliv_at(1), deliv_at(3));
    end
  endtask

  task automatic test_buffer();
    logic [64:0] want;
    want = {1'b0, 32'h0280_0400, RST_PC};
    do_reset();
    ok_pct = 100; dok_pct = 100; lat = 0; ds_pct = 0;
    ovr_en = 1'b1; ovr_inst = 32'h0280_0400;
    step(); step();
    checks++;
    if (obs_valid !== 1'b1 || obs_bus !== want) begin
      failures++;
      $display("FAIL buf_same_cycle valid=%b bus=%h required 1 %h", obs_valid, obs_bus, want);
    end
    ovr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs_valid !== 1'b1 || obs_bus !== want || obs_req !== 1'b0) begin
        failures++;
        $display("FAIL buf_hold[%0d] valid=%b req=%b bus=%h", i, obs_valid, obs_req, obs_bus);
      end
    end
    ds_pct = 100; ok_pct = 0;
    step();
    checks++;
    if (deliv_q.size() != 1 || deliv_at(0) !== want) begin
      failures++;
      $display("FAIL buf_deliver count=%0d got=%h required %h", deliv_q.size(), deliv_at(0), want);
    end
    checks++;
    if (obs_req !== 1'b1 || obs_addr !== RST_PC + 32'd4) begin
      failures++;
      $display("FAIL buf_leave_req req=%b addr=%h", obs_req, obs_addr);
    end
    repeat (3) step();
    checks++;
    if (deliv_q.size() != 1 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL buf_once count=%0d valid=%b required 1 0", deliv_q.size(), obs_valid);
    end
  endtask

  task automatic test_ex_ertn();
    do_reset();
    ok_pct = 100; dok_pct = 100; lat = 0; ds_pct = 0;
    nxt_ex_entry = 32'h1c00_8000; nxt_ertn_entry = 32'h1c00_4000;
    repeat (3) step();
    checks++;
    if (obs_valid !== 1'b1) begin
      failures++;
      $display("FAIL ex_setup valid=%b required 1", obs_valid);
    end
    step_r(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
      failures++;
      $display("FAIL ex_cycle valid=%b req=%b required 0 0", obs_valid, obs_req);
    end
    ds_pct = 100;
    repeat (4) step();
    checks++;
    if (issued_at(1) !== 32'h1c00_8000) begin
      failures++;
      $display("FAIL ex_next_addr got=%h required 1c008000", issued_at(1));
    end
    checks++;
    if (deliv_at(0) !== {1'b0, inst_of(32'h1c00_8000), 32'h1c00_8000}) begin
      failures++;
      $display("FAIL ex_buf_cleared got=%h", deliv_at(0));
    end
  endtask

  task automatic test_adef();
    int base;
    do_reset();
    ok_pct = 100; dok_pct = 100; lat = 0; ds_pct = 100;
    repeat (3) step();
    step_r(1'b0, 1'b0, 1'b1, 32'h1c00_0102);
    base = deliv_q.size();
    step();
    checks++;
    if (obs_req !== 1'b0 || obs_addr !== 32'h1c00_0102 || obs_valid !== 1'b0) begin
      failures++;
      $display("FAIL adef_noreq req=%b addr=%h valid=%b", obs_req, obs_addr, obs_valid);
    end
    step();
    checks++;
    if (obs_valid !== 1'b1 || obs_bus !== {1'b1, 32'h0, 32'h1c00_0102}) begin
      failures++;
      $display("FAIL adef_bus valid=%b bus=%h required 1 %h", obs_valid, obs_bus, {1'b1, 32'h0, 32'h1c00_0102});
    end
    repeat (4) step();
    checks++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b0 || deliv_q.size() != base + 1) begin
      failures++;
      $display("FAIL adef_idle req=%b valid=%b delivered=%0d required 0 0 %0d", obs_req, obs_valid,
               deliv_q.size(), base + 1);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, prev_addr, ex_t, ertn_t;
    logic        prev_pend, ex, ertn;
    int          ndeliv, r;
    do_reset();
    exp_pc = RST_PC; prev_pend = 1'b0; ndeliv = 0; prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        exp_pc = RST_PC; prev_pend = 1'b0;
      end
      ok_pct = 60; dok_pct = 70; ds_pct = 75; lat = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      ex   = (r < 2);
      ertn = (r == 0) || (r >= 2 && r < 4);
      ex_t   = 32'h1c00_0000 | {16'h0, $urandom_range(0, 16'h3fff) << 2};
      ertn_t = 32'h1c01_0000 | {16'h0, $urandom_range(0, 16'h3fff) << 2};
      nxt_ex_entry = ex_t; nxt_ertn_entry = ertn_t;
      step_r(ex, ertn, 1'b0, 32'h0);
      if (obs_redir) begin
        checks++;
        if (obs_valid !== 1'b0) begin
          failures++;
          $display("FAIL rnd_redir_valid c=%0d valid=%b required 0", c, obs_valid);
        end
      end
      if (prev_pend && !obs_redir) begin
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== prev_addr) begin
          failures++;
          $display("FAIL rnd_addr_stable c=%0d req=%b addr=%h required 1 %h", c, obs_req, obs_addr, prev_addr);
        end
      end
      checks++;
      if (bus_q.size() > 3) begin
        failures++;
        $display("FAIL rnd_ostd c=%0d inflight=%0d required <=3", c, bus_q.size());
      end
      if (obs_deliv) begin
        checks++;
        if (obs_bus !== {1'b0, inst_of(exp_pc), exp_pc}) begin
          failures++;
          $display("FAIL rnd_deliv c=%0d got=%h required=%h", c, obs_bus, {1'b0, inst_of(exp_pc), exp_pc});
        end
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
      if (ex) exp_pc = ex_t;
      else if (ertn) exp_pc = ertn_t;
      prev_pend = obs_req & ~obs_ok;
      prev_addr = obs_addr;
    end
    checks++;
    if (ndeliv < 200) begin
      failures++;
      $display("FAIL rnd_progress delivered=%0d required >=200", ndeliv);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    resetn = 1'b0;
    clear_inputs();
    ex_entry = '0; ertn_entry = '0; nxt_ex_entry = '0; nxt_ertn_entry = '0; ovr_inst = '0;
    ok_pct = 0; dok_pct = 0; ds_pct = 0; lat = 0;
    test_reset();
    test_seq_fetch();
    test_addr_stall();
    test_branch_cancel();
    test_buffer();
    test_ex_ertn();
    test_adef();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
